// File: rtl/ecc_read_scrub_28.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_read_scrub_28
//  Description : Read-return and scrub stage for 28-bit SRAM words protected
//                by a 28/7 SEC-DED code. Issues one read per request, corrects
//                single errors, flags double errors and, when enabled, writes
//                the corrected word back before returning it. Keeps
//                saturating corrected/uncorrectable error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ecc_read_scrub_28 #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter bit SCRUB_EN   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // request side
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    // single-port SRAM side
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [27:0]           mem_wdata_o,
    output logic [6:0]            mem_wecc_o,
    input  logic [27:0]           mem_rdata_i,
    input  logic [6:0]            mem_recc_i,
    // response side
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [27:0]           rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  rsp_ce_o,
    // error counters
    input  logic                  clr_cnt_i,
    output logic [CNT_WIDTH-1:0]  ce_count_o,
    output logic [CNT_WIDTH-1:0]  ue_count_o
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_READ    = 3'd1;
    localparam logic [2:0] c_CAPTURE = 3'd2;
    localparam logic [2:0] c_DECODE  = 3'd3;
    localparam logic [2:0] c_SCRUB   = 3'd4;
    localparam logic [2:0] c_RESP    = 3'd5;

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    // Codeword position of data bit idx; powers of two are reserved for
    // the six Hamming check bits.
    function automatic logic [5:0] f_data_pos(input int unsigned idx);
        if (idx == 0)       return 6'd3;
        else if (idx <= 3)  return 6'(idx + 32'd4);
        else if (idx <= 10) return 6'(idx + 32'd5);
        else if (idx <= 25) return 6'(idx + 32'd6);
        else                return 6'(idx + 32'd7);
    endfunction

    // Hamming check bits: bit k covers every data position with bit k set.
    function automatic logic [5:0] f_check_bits(input logic [27:0] d);
        logic [5:0] c;
        logic [5:0] p;
        c = '0;
        for (int i = 0; i < 28; i++) begin
            p = f_data_pos(i);
            for (int k = 0; k < 6; k++) begin
                if (p[k]) c[k] = c[k] ^ d[i];
            end
        end
        return c;
    endfunction

    // Full 7-bit check field: Hamming bits plus even overall parity.
    function automatic logic [6:0] f_encode(input logic [27:0] d);
        logic [5:0] c;
        c = f_check_bits(d);
        return {^{d, c}, c};
    endfunction

    logic [2:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [27:0]           raw_data_q, raw_data_d;
    logic [6:0]            raw_ecc_q,  raw_ecc_d;
    logic [27:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_err_q,  rsp_err_d;
    logic                  rsp_ce_q,   rsp_ce_d;
    logic [CNT_WIDTH-1:0]  ce_cnt_q,   ce_cnt_d;
    logic [CNT_WIDTH-1:0]  ue_cnt_q,   ue_cnt_d;

    logic [5:0]  w_syndrome;
    logic        w_single;
    logic        w_double;
    logic [27:0] w_corrected;
    logic        w_in_scrub;

    // SEC-DED decode of the captured word; a syndrome that points at a
    // check bit (or at 0, i.e. ecc[6]) leaves the data untouched.
    always_comb begin
        w_syndrome  = f_check_bits(raw_data_q) ^ raw_ecc_q[5:0];
        w_single    = ^{raw_data_q, raw_ecc_q};
        w_double    = !w_single && (w_syndrome != 6'd0);
        w_corrected = raw_data_q;
        for (int i = 0; i < 28; i++) begin
            if (w_single && (f_data_pos(i) == w_syndrome)) begin
                w_corrected[i] = ~raw_data_q[i];
            end
        end
    end

    // Transaction sequencing and response capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        raw_data_d = raw_data_q;
        raw_ecc_d  = raw_ecc_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_ce_d   = rsp_ce_q;
        case (state_q)
            c_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    state_d = c_READ;
                end
            end
            c_READ:    state_d = c_CAPTURE;
            c_CAPTURE: begin
                raw_data_d = mem_rdata_i;
                raw_ecc_d  = mem_recc_i;
                state_d    = c_DECODE;
            end
            c_DECODE: begin
                rsp_data_d = w_corrected;
                rsp_ce_d   = w_single;
                rsp_err_d  = w_double;
                state_d    = (w_single && SCRUB_EN) ? c_SCRUB : c_RESP;
            end
            c_SCRUB:   state_d = c_RESP;
            c_RESP: begin
                if (rsp_ready_i) state_d = c_IDLE;
            end
            default:   state_d = c_IDLE;
        endcase
    end

    // Saturating error counters; a clear overrides a same-cycle increment.
    always_comb begin
        ce_cnt_d = ce_cnt_q;
        ue_cnt_d = ue_cnt_q;
        if (clr_cnt_i) begin
            ce_cnt_d = '0;
            ue_cnt_d = '0;
        end else if (state_q == c_DECODE) begin
            if (w_single && (ce_cnt_q != c_CNT_MAX)) ce_cnt_d = ce_cnt_q + 1'b1;
            if (w_double && (ue_cnt_q != c_CNT_MAX)) ue_cnt_d = ue_cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= c_IDLE;
            addr_q     <= '0;
            raw_data_q <= '0;
            raw_ecc_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_ce_q   <= 1'b0;
            ce_cnt_q   <= '0;
            ue_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            raw_data_q <= raw_data_d;
            raw_ecc_q  <= raw_ecc_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_ce_q   <= rsp_ce_d;
            ce_cnt_q   <= ce_cnt_d;
            ue_cnt_q   <= ue_cnt_d;
        end
    end

    // SRAM strobes decode straight from state so reset kills them at once.
    always_comb begin
        w_in_scrub  = (state_q == c_SCRUB);
        mem_req_o   = (state_q == c_READ) || w_in_scrub;
        mem_we_o    = w_in_scrub;
        mem_addr_o  = addr_q;
        mem_wdata_o = w_in_scrub ? rsp_data_q : 28'd0;
        mem_wecc_o  = w_in_scrub ? f_encode(rsp_data_q) : 7'd0;
    end

    assign req_ready_o = (state_q == c_IDLE);
    assign rsp_valid_o = (state_q == c_RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_ce_o    = rsp_ce_q;
    assign ce_count_o  = ce_cnt_q;
    assign ue_count_o  = ue_cnt_q;

endmodule
`default_nettype wire
